ddr3_bringup_sequencer: RTL and testbench
=========================================

# ddr3_bringup_sequencer

Power-up and recovery sequencer for the DDR3 memory subsystem of the AE350 SoC top level. It takes the DDR3 PLL lock and the DDR3 controller's init-complete flag, and releases the resets in order: DDR3 controller reset first, SoC hardware reset (`HW_RSTN`) last. It detects calibration timeouts, pulses the DDR3 PLL reset and retries a bounded number of times. If every retry fails, it raises a sticky failure flag and holds the SoC in reset.

## Interface
Parameters:
- `LOCK_STABLE_CYC`, default 1024: consecutive synchronized-lock cycles required before DDR3 reset release.
- `INIT_TIMEOUT_CYC`, default 1000000: cycles allowed in WAIT_INIT for init-complete (20 ms at 50 MHz).
- `STOP_HOLD_CYC`, default 64: cycles PLL reset and DDR3 reset are held in RETRY.
- `MAX_RETRY`, default 3: retries before FAIL. Legal range 1..3.
- `CNT_W`, default 20: shared counter width. Must hold max(parameter) − 1.

Ports:
- `CLK`, input, 1: single clock (`DDR3_CLK_IN` domain, 50 MHz).
- `RSTN`, input, 1: asynchronous, active-low reset.
- `PLL_LOCK`, input, 1: DDR3 PLL lock, asynchronous. Synchronized internally with 2 flops.
- `DDR3_INIT_IN`, input, 1: DDR3 controller init/calibration complete, asynchronous. Synchronized internally with 2 flops.
- `PLL_RESET`, output, 1: active-high reset to the DDR3 PLL.
- `DDR3_RSTN_OUT`, output, 1: active-low reset to the DDR3 controller.
- `SOC_HW_RSTN`, output, 1: active-low `HW_RSTN` to the SoC.
- `READY`, output, 1: high only in RUN.
- `FAIL`, output, 1: sticky retry exhaustion.
- `RETRY_CNT`, output, 2: retries taken since `RSTN`. Saturates at `MAX_RETRY`.
- `STATE`, output, 3: current state encoding, for debug/GPIO.

## Operation
- States and `STATE` encodings: WAIT_LOCK=0, LOCK_STABLE=1, WAIT_INIT=2, RUN=3, RETRY=4, FAIL=5.
- All outputs are registered and change on the same edge as the state register.
- Output decode per state:
  - WAIT_LOCK, LOCK_STABLE: `DDR3_RSTN_OUT`=0, `SOC_HW_RSTN`=0, `PLL_RESET`=0.
  - WAIT_INIT: `DDR3_RSTN_OUT`=1, `SOC_HW_RSTN`=0.
  - RUN: both resets released, `READY`=1.
  - RETRY: `PLL_RESET`=1, both resets asserted.
  - FAIL: `PLL_RESET`=0, both resets asserted, `FAIL`=1.
- Transitions:
  - WAIT_LOCK: `lock_s`=1 → LOCK_STABLE, counter cleared.
  - LOCK_STABLE: `lock_s`=0 → WAIT_LOCK. Counter reaches `LOCK_STABLE_CYC`−1 with `lock_s`=1 → WAIT_INIT, counter cleared.
  - WAIT_INIT: `lock_s`=0 → WAIT_LOCK, with no retry counted. Otherwise `init_s`=1 → RUN. Otherwise counter at `INIT_TIMEOUT_CYC`−1 → RETRY.
  - RETRY: entered only when `RETRY_CNT` < `MAX_RETRY`, and `RETRY_CNT` increments on entry. The entry that would exceed the limit goes to FAIL instead. Leaves for WAIT_LOCK after `STOP_HOLD_CYC` cycles.
  - FAIL: terminal until `RSTN`.
  - RUN: terminal unless `DDR3_SEQ_WATCHDOG_EN` is defined.
- Simultaneous events:
  - Lock loss has priority over init or timeout.
  - In WAIT_INIT, `init_s` on the timeout cycle wins and goes to RUN.
- Counter behaviour: one `CNT_W`-bit counter, cleared on every state change, incrementing otherwise.

## Timing
- Reset values (`RSTN`=0): `PLL_RESET`=0, `DDR3_RSTN_OUT`=0, `SOC_HW_RSTN`=0, `READY`=0, `FAIL`=0, `RETRY_CNT`=0, `STATE`=0.
- `RSTN` asserted mid-operation returns everything to the reset values immediately, asynchronously.
- `PLL_LOCK` rising edge to entering LOCK_STABLE: 3 `CLK` edges (2 sync stages plus the state register).
- Lock stable to `DDR3_RSTN_OUT` rise: `LOCK_STABLE_CYC` cycles in LOCK_STABLE.
- `DDR3_INIT_IN` rise to `SOC_HW_RSTN`/`READY` rise: 3 edges.
- `PLL_RESET` pulse width: exactly `STOP_HOLD_CYC` cycles per retry.
- Timeout: `INIT_TIMEOUT_CYC` cycles in WAIT_INIT, then RETRY on the next edge.

## Configuration
- Macro: `DDR3_SEQ_WATCHDOG_EN`.
- Defined: in RUN, `lock_s`=0 or `init_s`=0 → RETRY (counted, with FAIL if exhausted). `SOC_HW_RSTN` falls 3 edges after the input drops.
- Undefined: RUN ignores `PLL_LOCK` and `DDR3_INIT_IN` until `RSTN`.

## Test plan
Bench parameters: `LOCK_STABLE_CYC`=8, `INIT_TIMEOUT_CYC`=32, `STOP_HOLD_CYC`=4, `MAX_RETRY`=2.
- Nominal: `PLL_LOCK`=1 at cycle 5, `DDR3_INIT_IN`=1 at cycle 30 → `DDR3_RSTN_OUT` rises cycle 16. `SOC_HW_RSTN`/`READY` rise cycle 33. `RETRY_CNT`=0.
- Lock glitch: `PLL_LOCK` low for 2 cycles mid-LOCK_STABLE → `STATE` back to 0. Full 8-cycle stability required again. `RETRY_CNT` unchanged.
- Timeout and retry: `DDR3_INIT_IN` held 0 → `PLL_RESET` high 4 cycles after 32 cycles in WAIT_INIT, `RETRY_CNT`=1. A second timeout gives `RETRY_CNT`=2. The third timeout gives `STATE`=5, `FAIL`=1, `SOC_HW_RSTN`=0.
- Tie: `DDR3_INIT_IN` synchronized high exactly on the timeout cycle → RUN, no `PLL_RESET`.
- Watchdog: in RUN, drop `PLL_LOCK` → with macro, `SOC_HW_RSTN`=0 after 3 edges and `RETRY_CNT` increments. Without macro, `READY` stays 1.
- Async reset: `RSTN` pulsed low during RETRY → all outputs at reset values before the next `CLK` edge, and `RETRY_CNT`=0.

Source files
------------

// File: rtl/ddr3_bringup_sequencer_if.sv
// DDR3 bring-up sequencer signal bundle.
// The master side drives PLL lock and init-complete; the slave side returns resets and status.
interface ddr3_bringup_sequencer_if;
  logic       PLL_LOCK;
  logic       DDR3_INIT_IN;
  logic       PLL_RESET;
  logic       DDR3_RSTN_OUT;
  logic       SOC_HW_RSTN;
  logic       READY;
  logic       FAIL;
  logic [1:0] RETRY_CNT;
  logic [2:0] STATE;

  modport master (
    output PLL_LOCK, DDR3_INIT_IN,
    input  PLL_RESET, DDR3_RSTN_OUT, SOC_HW_RSTN,
    input  READY, FAIL, RETRY_CNT, STATE
  );

  modport slave (
    input  PLL_LOCK, DDR3_INIT_IN,
    output PLL_RESET, DDR3_RSTN_OUT, SOC_HW_RSTN,
    output READY, FAIL, RETRY_CNT, STATE
  );
endinterface

// File: rtl/ddr3_bringup_sequencer.sv
// DDR3 power-up/recovery sequencer: ordered reset release, calibration timeout, bounded PLL retry.
// Define DDR3_SEQ_WATCHDOG_EN to make RUN fall back to RETRY on lock or init loss.
module ddr3_bringup_sequencer #(
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int INIT_TIMEOUT_CYC = 1000000,
  parameter int STOP_HOLD_CYC    = 64,
  parameter int MAX_RETRY        = 3,
  parameter int CNT_W            = 20
) (
  input logic CLK,
  input logic RSTN,
  ddr3_bringup_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_WAIT_LOCK   = 3'd0,
    S_LOCK_STABLE = 3'd1,
    S_WAIT_INIT   = 3'd2,
    S_RUN         = 3'd3,
    S_RETRY       = 3'd4,
    S_FAIL        = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LS_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(INIT_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] HD_LAST = CNT_W'(STOP_HOLD_CYC - 1);
  localparam logic [1:0]       RT_MAX  = 2'(MAX_RETRY);

  logic             r_lock_s1;
  logic             r_lock_s2;
  logic             r_init_s1;
  logic             r_init_s2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_retry;
  logic             r_pll_reset;
  logic             r_ddr3_rstn;
  logic             r_soc_rstn;
  logic             r_ready;
  logic             r_fail;

  state_t           w_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_retry_nxt;
  logic             w_fault;
  logic             w_lock_s;
  logic             w_init_s;

  assign w_lock_s = r_lock_s2;
  assign w_init_s = r_init_s2;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
      r_init_s1 <= 1'b0;
      r_init_s2 <= 1'b0;
    end else begin
      r_lock_s1 <= bus.PLL_LOCK;
      r_lock_s2 <= r_lock_s1;
      r_init_s1 <= bus.DDR3_INIT_IN;
      r_init_s2 <= r_init_s1;
    end
  end

  always_comb begin
    w_nxt       = r_state;
    w_retry_nxt = r_retry;
    w_fault     = 1'b0;
    unique case (r_state)
      S_WAIT_LOCK: begin
        if (w_lock_s) w_nxt = S_LOCK_STABLE;
      end
      S_LOCK_STABLE: begin
        if (!w_lock_s)             w_nxt = S_WAIT_LOCK;
        else if (r_cnt == LS_LAST) w_nxt = S_WAIT_INIT;
      end
      S_WAIT_INIT: begin
        if (!w_lock_s)             w_nxt = S_WAIT_LOCK;
        else if (w_init_s)         w_nxt = S_RUN;
        else if (r_cnt == TO_LAST) w_fault = 1'b1;
      end
      S_RUN: begin
`ifdef DDR3_SEQ_WATCHDOG_EN
        if (!w_lock_s || !w_init_s) w_fault = 1'b1;
`endif
      end
      S_RETRY: begin
        if (r_cnt == HD_LAST) w_nxt = S_WAIT_LOCK;
      end
      S_FAIL: w_nxt = S_FAIL;
      default: w_nxt = S_WAIT_LOCK;
    endcase
    // A fault only retries while budget remains; otherwise it is terminal.
    if (w_fault) begin
      if (r_retry < RT_MAX) begin
        w_nxt       = S_RETRY;
        w_retry_nxt = r_retry + 2'd1;
      end else begin
        w_nxt = S_FAIL;
      end
    end
    w_cnt_nxt = (w_nxt != r_state) ? '0 : r_cnt + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state     <= S_WAIT_LOCK;
      r_cnt       <= '0;
      r_retry     <= 2'd0;
      r_pll_reset <= 1'b0;
      r_ddr3_rstn <= 1'b0;
      r_soc_rstn  <= 1'b0;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retry     <= w_retry_nxt;
      r_pll_reset <= (w_nxt == S_RETRY);
      r_ddr3_rstn <= (w_nxt == S_WAIT_INIT) || (w_nxt == S_RUN);
      r_soc_rstn  <= (w_nxt == S_RUN);
      r_ready     <= (w_nxt == S_RUN);
      r_fail      <= r_fail || (w_nxt == S_FAIL);
    end
  end

  assign bus.PLL_RESET     = r_pll_reset;
  assign bus.DDR3_RSTN_OUT = r_ddr3_rstn;
  assign bus.SOC_HW_RSTN   = r_soc_rstn;
  assign bus.READY         = r_ready;
  assign bus.FAIL          = r_fail;
  assign bus.RETRY_CNT     = r_retry;
  assign bus.STATE         = r_state;

endmodule

// File: tb/tb_ddr3_bringup_sequencer.sv
// Directed bench for ddr3_bringup_sequencer with small timing parameters.
// Cycle numbers count rising CLK edges after RSTN release.
module tb_ddr3_bringup_sequencer;
  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  ddr3_bringup_sequencer_if bus();

  ddr3_bringup_sequencer #(
    .LOCK_STABLE_CYC (8),
    .INIT_TIMEOUT_CYC(32),
    .STOP_HOLD_CYC   (4),
    .MAX_RETRY       (2),
    .CNT_W           (20)
  ) dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    bus.PLL_LOCK = 1'b0;
    bus.DDR3_INIT_IN = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    cyc = 0;
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, "_pll"},   8'(bus.PLL_RESET), 8'd0);
    chk({tag, "_ddr"},   8'(bus.DDR3_RSTN_OUT), 8'd0);
    chk({tag, "_soc"},   8'(bus.SOC_HW_RSTN), 8'd0);
    chk({tag, "_rdy"},   8'(bus.READY), 8'd0);
    chk({tag, "_fail"},  8'(bus.FAIL), 8'd0);
    chk({tag, "_retry"}, 8'(bus.RETRY_CNT), 8'd0);
    chk({tag, "_state"}, 8'(bus.STATE), 8'd0);
  endtask

  initial begin
    bus.PLL_LOCK = 1'b0;
    bus.DDR3_INIT_IN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_all_reset("rst");

    // Nominal bring-up
    do_reset();
    tick_to(5);
    bus.PLL_LOCK = 1'b1;
    tick_to(7);
    chk("nom_wl7", 8'(bus.STATE), 8'd0);
    tick_to(8);
    chk("nom_ls8", 8'(bus.STATE), 8'd1);
    tick_to(15);
    chk("nom_ddr15", 8'(bus.DDR3_RSTN_OUT), 8'd0);
    tick_to(16);
    chk("nom_ddr16", 8'(bus.DDR3_RSTN_OUT), 8'd1);
    chk("nom_st16", 8'(bus.STATE), 8'd2);
    chk("nom_soc16", 8'(bus.SOC_HW_RSTN), 8'd0);
    tick_to(30);
    bus.DDR3_INIT_IN = 1'b1;
    tick_to(32);
    chk("nom_soc32", 8'(bus.SOC_HW_RSTN), 8'd0);
    tick_to(33);
    chk("nom_soc33", 8'(bus.SOC_HW_RSTN), 8'd1);
    chk("nom_rdy33", 8'(bus.READY), 8'd1);
    chk("nom_st33", 8'(bus.STATE), 8'd3);
    chk("nom_rt33", 8'(bus.RETRY_CNT), 8'd0);

    // Lock drop while in RUN
    bus.PLL_LOCK = 1'b0;
`ifdef DDR3_SEQ_WATCHDOG_EN
    tick_to(35);
    chk("wd_soc35", 8'(bus.SOC_HW_RSTN), 8'd1);
    tick_to(36);
    chk("wd_soc36", 8'(bus.SOC_HW_RSTN), 8'd0);
    chk("wd_st36", 8'(bus.STATE), 8'd4);
    chk("wd_rt36", 8'(bus.RETRY_CNT), 8'd1);
`else
    tick_to(40);
    chk("wd_rdy40", 8'(bus.READY), 8'd1);
    chk("wd_st40", 8'(bus.STATE), 8'd3);
    chk("wd_soc40", 8'(bus.SOC_HW_RSTN), 8'd1);
`endif

    // Lock glitch, then timeouts to FAIL
    do_reset();
    tick_to(5);
    bus.PLL_LOCK = 1'b1;
    tick_to(10);
    chk("gl_ls10", 8'(bus.STATE), 8'd1);
    bus.PLL_LOCK = 1'b0;
    tick_to(12);
    bus.PLL_LOCK = 1'b1;
    chk("gl_ls12", 8'(bus.STATE), 8'd1);
    tick_to(13);
    chk("gl_wl13", 8'(bus.STATE), 8'd0);
    tick_to(15);
    chk("gl_ls15", 8'(bus.STATE), 8'd1);
    tick_to(22);
    chk("gl_ls22", 8'(bus.STATE), 8'd1);
    tick_to(23);
    chk("gl_wi23", 8'(bus.STATE), 8'd2);
    chk("gl_rt23", 8'(bus.RETRY_CNT), 8'd0);
    tick_to(54);
    chk("to1_st54", 8'(bus.STATE), 8'd2);
    chk("to1_pll54", 8'(bus.PLL_RESET), 8'd0);
    tick_to(55);
    chk("to1_st55", 8'(bus.STATE), 8'd4);
    chk("to1_pll55", 8'(bus.PLL_RESET), 8'd1);
    chk("to1_ddr55", 8'(bus.DDR3_RSTN_OUT), 8'd0);
    chk("to1_rt55", 8'(bus.RETRY_CNT), 8'd1);
    tick_to(58);
    chk("to1_pll58", 8'(bus.PLL_RESET), 8'd1);
    tick_to(59);
    chk("to1_pll59", 8'(bus.PLL_RESET), 8'd0);
    chk("to1_st59", 8'(bus.STATE), 8'd0);
    tick_to(60);
    chk("to1_ls60", 8'(bus.STATE), 8'd1);
    tick_to(68);
    chk("to2_wi68", 8'(bus.STATE), 8'd2);
    tick_to(100);
    chk("to2_st100", 8'(bus.STATE), 8'd4);
    chk("to2_rt100", 8'(bus.RETRY_CNT), 8'd2);
    tick_to(113);
    chk("to3_wi113", 8'(bus.STATE), 8'd2);
    tick_to(144);
    chk("to3_fail144", 8'(bus.FAIL), 8'd0);
    tick_to(145);
    chk("to3_st145", 8'(bus.STATE), 8'd5);
    chk("to3_fail145", 8'(bus.FAIL), 8'd1);
    chk("to3_soc145", 8'(bus.SOC_HW_RSTN), 8'd0);
    chk("to3_pll145", 8'(bus.PLL_RESET), 8'd0);
    chk("to3_rt145", 8'(bus.RETRY_CNT), 8'd2);
    tick_to(160);
    chk("to3_st160", 8'(bus.STATE), 8'd5);
    chk("to3_fail160", 8'(bus.FAIL), 8'd1);

    // Init arriving exactly on the timeout cycle
    do_reset();
    tick_to(5);
    bus.PLL_LOCK = 1'b1;
    tick_to(16);
    chk("tie_wi16", 8'(bus.STATE), 8'd2);
    tick_to(45);
    bus.DDR3_INIT_IN = 1'b1;
    tick_to(47);
    chk("tie_wi47", 8'(bus.STATE), 8'd2);
    tick_to(48);
    chk("tie_run48", 8'(bus.STATE), 8'd3);
    chk("tie_pll48", 8'(bus.PLL_RESET), 8'd0);
    chk("tie_rdy48", 8'(bus.READY), 8'd1);
    chk("tie_rt48", 8'(bus.RETRY_CNT), 8'd0);

    // Asynchronous reset during RETRY
    do_reset();
    tick_to(5);
    bus.PLL_LOCK = 1'b1;
    tick_to(48);
    chk("ar_st48", 8'(bus.STATE), 8'd4);
    chk("ar_rt48", 8'(bus.RETRY_CNT), 8'd1);
    tick_to(49);
    RSTN = 1'b0;
    #2;
    chk_all_reset("ar");
    RSTN = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "bench timeout");
  end
endmodule
